exc_irq_controller: RTL and testbench
=====================================

Name: exc_irq_controller

Overview:
- Interrupt and exception controller for the single-cycle LEGv8 datapath.
- Collects NSRC external interrupt lines plus one synchronous exception request (e.g. invalid opcode from decode).
- Prioritises them and drives the datapath's Exc/EStatus inputs.
- Completes a request/acknowledge handshake on ExcAck, then holds off further exceptions until the handler executes ERET.

Parameters:
NSRC, 4, number of external interrupt sources (1..14); source i reports EStatus = i+1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
irq  input  NSRC  interrupt lines, synchronous to clk; rising edge requests.
mask_we  input  1  write enable for mask register.
mask_wdata  input  NSRC  new mask value (1 = source enabled).
sync_exc  input  1  synchronous exception request, single-cycle pulse.
sync_code  input  4  EStatus code for sync_exc (must be 0 or >NSRC).
ExcAck  input  1  datapath accepted exception (handler vector taken).
ERet  input  1  ERET instruction executing.
Exc  output  1  exception request to datapath.
EStatus  output  4  cause code presented with Exc.
pending  output  NSRC  latched, not yet serviced interrupt edges.
mask  output  NSRC  current mask register.
in_service  output  1  handler active (state SERVICE).
double_fault  output  1  sticky: sync_exc arrived while not IDLE.

Behaviour:
- Reset (reset=0, async):
  - State=IDLE.
  - Exc=0, EStatus=0, pending=0, mask=0, in_service=0, double_fault=0.
  - Edge-detect history = 0.
- Edge detect:
  - pending[i] sets at edge k when irq[i]=1 at k and irq[i]=0 at k-1; edges are latched regardless of mask or state.
  - pending[i] clears on ExcAck acceptance when the captured cause is source i.
  - A new edge on the same cycle as that clear wins: pending stays 1.
- Mask:
  - mask_we at edge k loads mask_wdata in all states.
  - Effective request = pending & mask; masked pending bits are retained.
- FSM states: IDLE, REQ, SERVICE, RET.
  - IDLE:
    - sync_exc=1 -> REQ with EStatus=sync_code. sync_exc has highest priority.
    - Else, if any pending&mask bit is set -> REQ with EStatus = (lowest set index)+1, index captured internally.
    - Latency: sync_exc sampled at edge k gives Exc=1 after edge k. irq rising at edge k gives pending after edge k and Exc=1 after edge k+1.
  - REQ:
    - Exc=1; EStatus and captured cause frozen (higher-priority arrivals do not preempt).
    - ExcAck=1 at edge -> SERVICE; Exc=0 after that edge; pending bit cleared if cause was an irq.
    - Exc may be acknowledged the first cycle it is high.
  - SERVICE:
    - in_service=1, Exc=0; EStatus holds the cause for handler reads.
    - ERet=1 -> RET. ExcAck ignored.
  - RET:
    - One cycle; in_service=0, Exc=0 -> IDLE.
    - Guarantees Exc never asserts in the cycle after ERet; earliest re-request is Exc=1 two edges after ERet.
    - EStatus is cleared to 0 on entry to RET.
- ERet outside SERVICE is ignored.
- sync_exc in REQ, SERVICE or RET:
  - Ignored, with no nesting.
  - Sets double_fault (sticky until reset).
- A pending edge while not IDLE waits; it is requested from IDLE in priority order.
- Mask cleared while in REQ: request is not withdrawn; the handshake completes.
- Reset mid-handshake: everything returns to reset values immediately; Exc drops asynchronously.
- All outputs are registered; no combinational path from any input to Exc or EStatus.

Test Plan:
1. Reset, mask_we with 4'b0101, pulse irq[2] -> pending=4'b0100 after 1 edge; Exc=1, EStatus=3 after next edge. ExcAck -> Exc=0, pending=0, in_service=1. ERet -> RET for 1 cycle, then IDLE.
2. mask=4'b1111, irq[3] and irq[1] rise together -> EStatus=2. After ERet, Exc re-asserts with EStatus=4 exactly 2 edges after ERet.
3. sync_exc with sync_code=4'hE on the same edge as irq[0] rising -> EStatus=4'hE first. irq[0] is served after ERet with EStatus=1.
4. irq[1] edge with mask=0 -> pending=4'b0010, Exc stays 0. mask_we with 4'b0010 -> Exc=1 with EStatus=2 one edge later.
5. sync_exc during SERVICE -> no Exc, double_fault=1, persists through ERet. Then drive reset=0 mid-REQ -> Exc=0 and all outputs zero immediately.
6. irq[0] re-rises on the ExcAck edge of its own request -> pending[0] remains 1. After ERet it is serviced again with EStatus=1.

Source files
------------

// File: rtl/exc_irq_controller.sv
// ----------------------------------------------------------------------------
// exc_irq_controller
//
// Interrupt / exception controller for the single-cycle LEGv8 datapath.
// Latches rising edges on NSRC external interrupt lines, merges them with a
// synchronous exception request from decode, and presents one prioritised
// cause at a time to the datapath through a request/acknowledge handshake
// (Exc / ExcAck). Once a cause is accepted, further requests are held off
// until the handler executes ERET.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   irq          interrupt lines (synchronous to clk), rising edge requests
//   mask_we      mask register write enable
//   mask_wdata   new mask value (1 = source enabled)
//   sync_exc     synchronous exception request, single-cycle pulse
//   sync_code    EStatus code reported for sync_exc (0 or > NSRC)
//   ExcAck       datapath accepted the exception (vector taken)
//   ERet         ERET instruction executing
//   Exc          exception request to datapath (registered)
//   EStatus      cause code presented with Exc (registered)
//   pending      latched interrupt edges not yet serviced
//   mask         current mask register
//   in_service   handler active
//   double_fault sticky: sync_exc seen while a handshake/handler was active
// ----------------------------------------------------------------------------
module exc_irq_controller #(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            sync_exc,
    input  logic [3:0]      sync_code,
    input  logic            ExcAck,
    input  logic            ERet,
    output logic            Exc,
    output logic [3:0]      EStatus,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic            in_service,
    output logic            double_fault
);

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RET     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [NSRC-1:0]  irq_prev;
    logic [NSRC-1:0]  irq_rise;
    logic [NSRC-1:0]  req_vec;
    logic             req_any;
    logic [IDX_W-1:0] req_idx;

    logic             cause_is_irq;
    logic             cause_is_irq_nx;
    logic [IDX_W-1:0] cause_idx;
    logic [IDX_W-1:0] cause_idx_nx;
    logic [3:0]       estatus_nx;
    logic [NSRC-1:0]  pending_nx;
    logic             ack_take;

    assign irq_rise = irq & ~irq_prev;

    // Masked-off pending bits stay latched; they simply do not compete.
    assign req_vec = pending & mask;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        req_any = 1'b0;
        req_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                req_any = 1'b1;
                req_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and cause capture
    // ------------------------------------------------------------------
    always_comb begin
        state_nx        = state;
        estatus_nx      = EStatus;
        cause_is_irq_nx = cause_is_irq;
        cause_idx_nx    = cause_idx;
        ack_take        = 1'b0;
        case (state)
            IDLE: begin
                // IDLE looks at the registered pending vector, so a fresh
                // irq edge is requested one edge after it was latched.
                if (sync_exc) begin
                    state_nx        = REQ;
                    estatus_nx      = sync_code;
                    cause_is_irq_nx = 1'b0;
                end else if (req_any) begin
                    state_nx        = REQ;
                    estatus_nx      = 4'(req_idx) + 4'd1;
                    cause_is_irq_nx = 1'b1;
                    cause_idx_nx    = req_idx;
                end
            end
            REQ: begin
                // Cause is frozen here; neither mask changes nor newer
                // arrivals withdraw or replace the outstanding request.
                if (ExcAck) begin
                    state_nx = SERVICE;
                    ack_take = 1'b1;
                end
            end
            SERVICE: begin
                if (ERet) begin
                    state_nx   = RET;
                    estatus_nx = 4'd0;
                end
            end
            RET: begin
                // Dead cycle so Exc cannot rise in the cycle right after ERET.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Clear the serviced bit first, then OR in new edges so a re-rise on
    // the acknowledge edge is not lost.
    always_comb begin
        pending_nx = pending;
        if (ack_take && cause_is_irq) begin
            pending_nx[cause_idx] = 1'b0;
        end
        pending_nx = pending_nx | irq_rise;
    end

    // ------------------------------------------------------------------
    // Registered outputs and bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev     <= '0;
            pending      <= '0;
            mask         <= '0;
            Exc          <= 1'b0;
            EStatus      <= 4'd0;
            in_service   <= 1'b0;
            double_fault <= 1'b0;
            cause_is_irq <= 1'b0;
            cause_idx    <= '0;
        end else begin
            irq_prev     <= irq;
            pending      <= pending_nx;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            Exc          <= (state_nx == REQ);
            EStatus      <= estatus_nx;
            in_service   <= (state_nx == SERVICE);
            if (sync_exc && (state != IDLE)) begin
                double_fault <= 1'b1;
            end
            cause_is_irq <= cause_is_irq_nx;
            cause_idx    <= cause_idx_nx;
        end
    end

endmodule

// File: tb/tb_exc_irq_controller.sv
// ----------------------------------------------------------------------------
// tb_exc_irq_controller
//
// Self-checking bench for exc_irq_controller (NSRC = 4). A table of
// {inputs, expected outputs} records is driven one clock at a time; the
// expected record is queued when the inputs are driven and popped and
// compared after the following rising edge. Hand-written sequences cover
// the reset-during-request and edge-history corner cases.
// ----------------------------------------------------------------------------
module tb_exc_irq_controller;

    localparam int NSRC = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            sync_exc;
    logic [3:0]      sync_code;
    logic            ExcAck;
    logic            ERet;
    logic            Exc;
    logic [3:0]      EStatus;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic            in_service;
    logic            double_fault;

    always #5 clk = ~clk;

    exc_irq_controller #(.NSRC(NSRC)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .sync_exc     (sync_exc),
        .sync_code    (sync_code),
        .ExcAck       (ExcAck),
        .ERet         (ERet),
        .Exc          (Exc),
        .EStatus      (EStatus),
        .pending      (pending),
        .mask         (mask),
        .in_service   (in_service),
        .double_fault (double_fault)
    );

    typedef struct packed {
        logic       exc;
        logic [3:0] es;
        logic [3:0] pend;
        logic [3:0] msk;
        logic       ins;
        logic       df;
    } out_t;

    typedef struct {
        logic [3:0] irq_v;
        logic       mwe;
        logic [3:0] mwd;
        logic       sx;
        logic [3:0] sc;
        logic       ack;
        logic       eret;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(
        input logic [3:0] irq_v, input logic mwe, input logic [3:0] mwd,
        input logic sx, input logic [3:0] sc, input logic ack, input logic eret,
        input logic e_exc, input logic [3:0] e_es, input logic [3:0] e_pend,
        input logic [3:0] e_msk, input logic e_ins, input logic e_df);
        vec_t v;
        v.irq_v    = irq_v;
        v.mwe      = mwe;
        v.mwd      = mwd;
        v.sx       = sx;
        v.sc       = sc;
        v.ack      = ack;
        v.eret     = eret;
        v.exp.exc  = e_exc;
        v.exp.es   = e_es;
        v.exp.pend = e_pend;
        v.exp.msk  = e_msk;
        v.exp.ins  = e_ins;
        v.exp.df   = e_df;
        return v;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.exc  = Exc;
        o.es   = EStatus;
        o.pend = pending;
        o.msk  = mask;
        o.ins  = in_service;
        o.df   = double_fault;
        return o;
    endfunction

    function automatic out_t zeros();
        out_t o;
        o = '0;
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got exc=%0b es=%h pend=%b mask=%b insvc=%0b df=%0b, expected exc=%0b es=%h pend=%b mask=%b insvc=%0b df=%0b",
                     name, got.exc, got.es, got.pend, got.msk, got.ins, got.df,
                     exp.exc, exp.es, exp.pend, exp.msk, exp.ins, exp.df);
        end
    endtask

    task automatic drive_idle();
        irq        = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        sync_exc   = 1'b0;
        sync_code  = 4'd0;
        ExcAck     = 1'b0;
        ERet       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t e;
        out_t want;

        //     irq  we mwd sx sc  ack er | exc es  pend msk ins df
        // Plan 1: single masked-in source, full handshake
        vecs.push_back(mk(4'h0,1,4'h5,0,4'h0,0,0, 0,4'h0,4'h0,4'h5,0,0));
        vecs.push_back(mk(4'h4,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h4,4'h5,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 1,4'h3,4'h4,4'h5,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,1,0, 0,4'h3,4'h0,4'h5,1,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h3,4'h0,4'h5,1,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h0,4'h5,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h0,4'h5,0,0));
        // Plan 2: simultaneous edges, priority and ERET-to-request spacing
        vecs.push_back(mk(4'h0,1,4'hF,0,4'h0,0,0, 0,4'h0,4'h0,4'hF,0,0));
        vecs.push_back(mk(4'hA,0,4'h0,0,4'h0,0,0, 0,4'h0,4'hA,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 1,4'h2,4'hA,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,1,0, 0,4'h2,4'h8,4'hF,1,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h8,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h8,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 1,4'h4,4'h8,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,1,0, 0,4'h4,4'h0,4'hF,1,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h0,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h0,4'hF,0,0));
        // Plan 3: sync_exc beats a simultaneous irq edge
        vecs.push_back(mk(4'h1,0,4'h0,1,4'hE,0,0, 1,4'hE,4'h1,4'hF,0,0));
        vecs.push_back(mk(4'h1,0,4'h0,0,4'h0,1,0, 0,4'hE,4'h1,4'hF,1,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h1,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h1,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 1,4'h1,4'h1,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,1,0, 0,4'h1,4'h0,4'hF,1,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h0,4'hF,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h0,4'hF,0,0));
        // Plan 4: masked edge waits, unmask releases it; unmask in REQ keeps request
        vecs.push_back(mk(4'h0,1,4'h0,0,4'h0,0,0, 0,4'h0,4'h0,4'h0,0,0));
        vecs.push_back(mk(4'h2,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h2,4'h0,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h2,4'h0,0,0));
        vecs.push_back(mk(4'h0,1,4'h2,0,4'h0,0,0, 0,4'h0,4'h2,4'h2,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 1,4'h2,4'h2,4'h2,0,0));
        vecs.push_back(mk(4'h0,1,4'h0,0,4'h0,0,0, 1,4'h2,4'h2,4'h0,0,0));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,1,0, 0,4'h2,4'h0,4'h0,1,0));
        // Plan 5 (first half): sync_exc during SERVICE -> sticky double fault
        vecs.push_back(mk(4'h0,0,4'h0,1,4'hF,0,0, 0,4'h2,4'h0,4'h0,1,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h0,4'h0,0,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h0,4'h0,0,1));
        // Plan 6: re-rise on the acknowledge edge survives the clear
        vecs.push_back(mk(4'h0,1,4'h1,0,4'h0,0,0, 0,4'h0,4'h0,4'h1,0,1));
        vecs.push_back(mk(4'h1,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h1,4'h1,0,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 1,4'h1,4'h1,4'h1,0,1));
        vecs.push_back(mk(4'h1,0,4'h0,0,4'h0,1,0, 0,4'h1,4'h1,4'h1,1,1));
        vecs.push_back(mk(4'h1,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h1,4'h1,0,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h1,4'h1,0,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 1,4'h1,4'h1,4'h1,0,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,1,0, 0,4'h1,4'h0,4'h1,1,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,1, 0,4'h0,4'h0,4'h1,0,1));
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,0,0, 0,4'h0,4'h0,4'h1,0,1));
        // ERet / ExcAck while IDLE are ignored
        vecs.push_back(mk(4'h0,0,4'h0,0,4'h0,1,1, 0,4'h0,4'h0,4'h1,0,1));

        // Reset state
        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), zeros());
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            irq        = vecs[i].irq_v;
            mask_we    = vecs[i].mwe;
            mask_wdata = vecs[i].mwd;
            sync_exc   = vecs[i].sx;
            sync_code  = vecs[i].sc;
            ExcAck     = vecs[i].ack;
            ERet       = vecs[i].eret;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), sample(), e);
        end

        // Sync exception request from IDLE (state: IDLE, mask=0001, df=1)
        @(negedge clk);
        drive_idle();
        sync_exc  = 1'b1;
        sync_code = 4'h5;
        @(posedge clk);
        #1;
        want = '{exc:1'b1, es:4'h5, pend:4'h0, msk:4'h1, ins:1'b0, df:1'b1};
        check("sync_req", sample(), want);

        // Second sync_exc and a new irq edge while in REQ: cause stays frozen
        @(negedge clk);
        sync_exc  = 1'b1;
        sync_code = 4'h9;
        irq       = 4'h1;
        @(posedge clk);
        #1;
        want = '{exc:1'b1, es:4'h5, pend:4'h1, msk:4'h1, ins:1'b0, df:1'b1};
        check("req_frozen", sample(), want);

        // Asynchronous reset mid-REQ: outputs drop before the next edge
        @(negedge clk);
        drive_idle();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", sample(), zeros());
        @(posedge clk);
        #1;
        check("reset_hold", sample(), zeros());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", sample(), zeros());

        // Edge history was cleared by reset: a line high now counts as an edge
        @(negedge clk);
        irq = 4'h4;
        @(posedge clk);
        #1;
        want = '{exc:1'b0, es:4'h0, pend:4'h4, msk:4'h0, ins:1'b0, df:1'b0};
        check("history_reset", sample(), want);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
